// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_if
// Purpose  : Bus port bundle between the load/store unit and the memory/IO bus.
// Revision : 1.0
// ============================================================================

`ifndef MEM_LSU_DEFS
`define MEM_LSU_DEFS
`define AluOpBus    7:0
`define RegAddrBus  4:0
`define NOPRegAddr  5'b00000
`define EXE_LB_OP   8'b11100000
`define EXE_LH_OP   8'b11100001
`define EXE_LW_OP   8'b11100011
`define EXE_LBU_OP  8'b11100100
`define EXE_LHU_OP  8'b11100101
`define EXE_SB_OP   8'b11101000
`define EXE_SH_OP   8'b11101001
`define EXE_SW_OP   8'b11101011
`endif

interface mem_lsu_if;
   // Names are taken from the LSU side: _o leaves the LSU, _i enters it.
   logic        bus_req_o;
   logic        bus_io_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_data_o;
   logic        bus_ack_i;
   logic [31:0] bus_data_i;

   modport master (
      output bus_req_o, bus_io_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o,
      input  bus_ack_i, bus_data_i
   );

   modport slave (
      input  bus_req_o, bus_io_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o,
      output bus_ack_i, bus_data_i
   );
endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : Load/store unit: alignment check, lane steering, bus timeout.
// Revision : 1.0
// ============================================================================

`ifndef MEM_LSU_DEFS
`define MEM_LSU_DEFS
`define AluOpBus    7:0
`define RegAddrBus  4:0
`define NOPRegAddr  5'b00000
`define EXE_LB_OP   8'b11100000
`define EXE_LH_OP   8'b11100001
`define EXE_LW_OP   8'b11100011
`define EXE_LBU_OP  8'b11100100
`define EXE_LHU_OP  8'b11100101
`define EXE_SB_OP   8'b11101000
`define EXE_SH_OP   8'b11101001
`define EXE_SW_OP   8'b11101011
`endif

module mem_lsu #(
   parameter logic [31:0] IO_BASE    = 32'hFFFF0000,
   parameter int          TIMEOUT    = 15,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               req_valid_i,
   input  wire logic [`AluOpBus]   aluop_i,
   input  wire logic [31:0]        mem_addr_i,
   input  wire logic [31:0]        reg2_i,
   input  wire logic [`RegAddrBus] wd_i,
   input  wire logic               wreg_i,
   input  wire logic [31:0]        wdata_i,
   output logic                    wb_valid_o,
   output logic [`RegAddrBus]      wd_o,
   output logic                    wreg_o,
   output logic [31:0]             wdata_o,
   output logic [1:0]              exc_o,
   output logic                    stall_o,
   mem_lsu_if.master               bus
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_e;

   function automatic logic is_load(input logic [`AluOpBus] op);
      return op inside {`EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP};
   endfunction

   function automatic logic is_store(input logic [`AluOpBus] op);
      return op inside {`EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP};
   endfunction

   // Physical byte lane (0 = bits [7:0]) holding memory byte offset off.
   function automatic logic [1:0] lane(input logic [1:0] off);
      return BIG_ENDIAN ? (2'd3 - off) : off;
   endfunction

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [`AluOpBus]   op_q, op_d;
   logic               wb_valid_q, wb_valid_d, wreg_q, wreg_d, stall_q, stall_d;
   logic [`RegAddrBus] wd_q, wd_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [1:0]         exc_q, exc_d;
   logic               req_q, req_d, io_q, io_d, we_q, we_d;
   logic [31:0]        addr_q, addr_d, bdata_q, bdata_d;
   logic [3:0]         sel_q, sel_d;

   logic               w_half, w_word, w_misal, w_hlane;
   logic [3:0]         w_sel;
   logic [31:0]        w_sdata, w_ldata;
   logic [7:0]         w_byte;
   logic [15:0]        w_hword;

   always_comb begin
      w_half  = aluop_i inside {`EXE_LH_OP, `EXE_LHU_OP, `EXE_SH_OP};
      w_word  = aluop_i inside {`EXE_LW_OP, `EXE_SW_OP};
      w_misal = (w_half && mem_addr_i[0]) || (w_word && (mem_addr_i[1:0] != 2'b00));
      if (w_word) begin
         w_sel = 4'b1111;
      end else if (w_half) begin
         w_sel = (4'b0001 << lane(mem_addr_i[1:0])) | (4'b0001 << lane(mem_addr_i[1:0] | 2'b01));
      end else begin
         w_sel = 4'b0001 << lane(mem_addr_i[1:0]);
      end
      case (aluop_i)
         `EXE_SB_OP: w_sdata = {4{reg2_i[7:0]}};
         `EXE_SH_OP: w_sdata = {2{reg2_i[15:0]}};
         default:    w_sdata = reg2_i;
      endcase
   end

   // Upper halfword holds offset 0 when big-endian, offset 2 when little-endian.
   always_comb begin
      w_hlane = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
      w_byte  = bus.bus_data_i[{lane(addr_q[1:0]), 3'b000} +: 8];
      w_hword = bus.bus_data_i[{w_hlane, 4'b0000} +: 16];
      case (op_q)
         `EXE_LB_OP:  w_ldata = {{24{w_byte[7]}}, w_byte};
         `EXE_LBU_OP: w_ldata = {24'h0, w_byte};
         `EXE_LH_OP:  w_ldata = {{16{w_hword[15]}}, w_hword};
         `EXE_LHU_OP: w_ldata = {16'h0, w_hword};
         default:     w_ldata = bus.bus_data_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      wb_valid_d = 1'b0;
      exc_d      = 2'b00;
      stall_d    = 1'b0;
      wd_d       = wd_q;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      req_d      = 1'b0;
      io_d       = io_q;
      we_d       = we_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      bdata_d    = bdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               wd_d = wd_i;
               op_d = aluop_i;
               if (!is_load(aluop_i) && !is_store(aluop_i)) begin
                  wreg_d     = wreg_i;
                  wdata_d    = wdata_i;
                  wb_valid_d = 1'b1;
               end else if (w_misal) begin
                  wreg_d     = 1'b0;
                  wdata_d    = 32'h0;
                  exc_d      = is_load(aluop_i) ? 2'b01 : 2'b10;
                  wb_valid_d = 1'b1;
                  stall_d    = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  wreg_d  = is_load(aluop_i) && wreg_i;
                  req_d   = 1'b1;
                  io_d    = (mem_addr_i >= IO_BASE);
                  we_d    = is_store(aluop_i);
                  addr_d  = mem_addr_i;
                  sel_d   = w_sel;
                  bdata_d = w_sdata;
                  cnt_d   = '0;
                  stall_d = 1'b1;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            stall_d = 1'b1;
            if (bus.bus_ack_i) begin
               if (is_load(op_q)) begin
                  wdata_d = w_ldata;
               end
               wb_valid_d = 1'b1;
               state_d    = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               wreg_d     = 1'b0;
               exc_d      = 2'b11;
               wb_valid_d = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
               req_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         wb_valid_q <= 1'b0;
         exc_q      <= 2'b00;
         stall_q    <= 1'b0;
         wd_q       <= `NOPRegAddr;
         wreg_q     <= 1'b0;
         wdata_q    <= 32'h0;
         req_q      <= 1'b0;
         io_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         sel_q      <= 4'h0;
         bdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         wb_valid_q <= wb_valid_d;
         exc_q      <= exc_d;
         stall_q    <= stall_d;
         wd_q       <= wd_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         req_q      <= req_d;
         io_q       <= io_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         bdata_q    <= bdata_d;
      end
   end

   assign wb_valid_o     = wb_valid_q;
   assign wd_o           = wd_q;
   assign wreg_o         = wreg_q;
   assign wdata_o        = wdata_q;
   assign exc_o          = exc_q;
   assign stall_o        = stall_q;
   assign bus.bus_req_o  = req_q;
   assign bus.bus_io_o   = io_q;
   assign bus.bus_we_o   = we_q;
   assign bus.bus_addr_o = addr_q;
   assign bus.bus_sel_o  = sel_q;
   assign bus.bus_data_o = bdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Directed self-checking bench for mem_lsu (big- and little-endian).
// Revision : 1.0
// ============================================================================

`ifndef MEM_LSU_DEFS
`define MEM_LSU_DEFS
`define AluOpBus    7:0
`define RegAddrBus  4:0
`define NOPRegAddr  5'b00000
`define EXE_LB_OP   8'b11100000
`define EXE_LH_OP   8'b11100001
`define EXE_LW_OP   8'b11100011
`define EXE_LBU_OP  8'b11100100
`define EXE_LHU_OP  8'b11100101
`define EXE_SB_OP   8'b11101000
`define EXE_SH_OP   8'b11101001
`define EXE_SW_OP   8'b11101011
`endif

module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_be, req_le, wreg;
   logic [7:0]  aluop;
   logic [31:0] addr, reg2, wdat;
   logic [4:0]  wd;

   logic        wb_be, wreg_be, stall_be, wb_le, wreg_le, stall_le;
   logic [4:0]  wd_be, wd_le;
   logic [31:0] wdata_be, wdata_le;
   logic [1:0]  exc_be, exc_le;

   mem_lsu_if bus_be ();
   mem_lsu_if bus_le ();

   mem_lsu #(.IO_BASE(32'hFFFF0000), .TIMEOUT(15), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .rst(rst_n), .req_valid_i(req_be), .aluop_i(aluop), .mem_addr_i(addr),
      .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdat), .wb_valid_o(wb_be),
      .wd_o(wd_be), .wreg_o(wreg_be), .wdata_o(wdata_be), .exc_o(exc_be),
      .stall_o(stall_be), .bus(bus_be)
   );

   mem_lsu #(.IO_BASE(32'hFFFF0000), .TIMEOUT(15), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .rst(rst_n), .req_valid_i(req_le), .aluop_i(aluop), .mem_addr_i(addr),
      .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdat), .wb_valid_o(wb_le),
      .wd_o(wd_le), .wreg_o(wreg_le), .wdata_o(wdata_le), .exc_o(exc_le),
      .stall_o(stall_le), .bus(bus_le)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Observations gathered by issue(); first bus beat and first writeback are kept.
   int          o_req_cnt, o_stall_cnt, o_wb_cnt, o_wb_at;
   logic [3:0]  o_sel;
   logic        o_we, o_io, o_wreg;
   logic [31:0] o_addr, o_bdata, o_wdata;
   logic [1:0]  o_exc;

   task automatic issue(input bit le, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] r2, input logic [31:0] rdata,
                        input int ack_after, input int ncyc);
      logic s_req, s_stall, s_wb, s_ack;
      o_req_cnt = 0; o_stall_cnt = 0; o_wb_cnt = 0; o_wb_at = -1;
      o_sel = 4'h0; o_we = 1'b0; o_io = 1'b0; o_wreg = 1'b0;
      o_addr = 32'h0; o_bdata = 32'h0; o_wdata = 32'h0; o_exc = 2'b00;
      bus_be.bus_data_i = rdata; bus_le.bus_data_i = rdata;
      bus_be.bus_ack_i = 1'b0;   bus_le.bus_ack_i = 1'b0;
      @(posedge clk); #1;
      aluop = op; addr = a; reg2 = r2; wd = 5'd7; wreg = 1'b1; wdat = 32'h0;
      if (le) req_le = 1'b1; else req_be = 1'b1;
      @(posedge clk); #1;
      req_be = 1'b0; req_le = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         s_req   = le ? bus_le.bus_req_o : bus_be.bus_req_o;
         s_stall = le ? stall_le : stall_be;
         s_wb    = le ? wb_le : wb_be;
         if (s_req) begin
            if (o_req_cnt == 0) begin
               o_sel   = le ? bus_le.bus_sel_o  : bus_be.bus_sel_o;
               o_we    = le ? bus_le.bus_we_o   : bus_be.bus_we_o;
               o_io    = le ? bus_le.bus_io_o   : bus_be.bus_io_o;
               o_addr  = le ? bus_le.bus_addr_o : bus_be.bus_addr_o;
               o_bdata = le ? bus_le.bus_data_o : bus_be.bus_data_o;
            end
            o_req_cnt++;
         end
         if (s_stall) o_stall_cnt++;
         if (s_wb) begin
            if (o_wb_cnt == 0) begin
               o_wb_at = c;
               o_wdata = le ? wdata_le : wdata_be;
               o_wreg  = le ? wreg_le : wreg_be;
               o_exc   = le ? exc_le : exc_be;
            end
            o_wb_cnt++;
         end
         s_ack = s_req && (o_req_cnt == ack_after + 1);
         if (le) bus_le.bus_ack_i = s_ack; else bus_be.bus_ack_i = s_ack;
      end
      bus_be.bus_ack_i = 1'b0; bus_le.bus_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      tests++; if (bus_be.bus_req_o !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", bus_be.bus_req_o); end
      tests++; if (wb_be !== 1'b0 || wb_le !== 1'b0) begin fails++; $display("FAIL rst_wb got=%b%b exp=00", wb_be, wb_le); end
      tests++; if (stall_be !== 1'b0) begin fails++; $display("FAIL rst_stall got=%b exp=0", stall_be); end
      tests++; if (exc_be !== 2'b00) begin fails++; $display("FAIL rst_exc got=%b exp=00", exc_be); end
      tests++; if (wd_be !== `NOPRegAddr) begin fails++; $display("FAIL rst_wd got=%h exp=%h", wd_be, `NOPRegAddr); end
      tests++; if (wdata_be !== 32'h0 || wreg_be !== 1'b0) begin fails++; $display("FAIL rst_wdata got=%h/%b exp=0/0", wdata_be, wreg_be); end
      tests++; if (bus_be.bus_sel_o !== 4'h0 || bus_be.bus_addr_o !== 32'h0) begin fails++; $display("FAIL rst_bus got=%b/%h exp=0/0", bus_be.bus_sel_o, bus_be.bus_addr_o); end
   endtask

   task automatic test_load_byte();
      issue(1'b0, `EXE_LB_OP, 32'h0000_0101, 32'h0, 32'h11F2_3344, 2, 8);
      tests++; if (o_sel !== 4'b0100) begin fails++; $display("FAIL lb_sel got=%b exp=0100", o_sel); end
      tests++; if (o_addr !== 32'h101 || o_we !== 1'b0) begin fails++; $display("FAIL lb_addr got=%h/%b exp=101/0", o_addr, o_we); end
      tests++; if (o_req_cnt !== 3) begin fails++; $display("FAIL lb_req_cycles got=%0d exp=3", o_req_cnt); end
      tests++; if (o_wdata !== 32'hFFFF_FFF2) begin fails++; $display("FAIL lb_wdata got=%h exp=fffffff2", o_wdata); end
      tests++; if (o_wb_cnt !== 1) begin fails++; $display("FAIL lb_wb_pulses got=%0d exp=1", o_wb_cnt); end
      tests++; if (o_stall_cnt !== 4) begin fails++; $display("FAIL lb_stall_cycles got=%0d exp=4", o_stall_cnt); end
      tests++; if (o_wreg !== 1'b1 || o_exc !== 2'b00) begin fails++; $display("FAIL lb_wreg_exc got=%b/%b exp=1/00", o_wreg, o_exc); end
   endtask

   task automatic test_store_half();
      issue(1'b0, `EXE_SH_OP, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 0, 6);
      tests++; if (o_sel !== 4'b0011) begin fails++; $display("FAIL sh_sel got=%b exp=0011", o_sel); end
      tests++; if (o_bdata !== 32'hBEEF_BEEF) begin fails++; $display("FAIL sh_data got=%h exp=beefbeef", o_bdata); end
      tests++; if (o_we !== 1'b1 || o_io !== 1'b0) begin fails++; $display("FAIL sh_we_io got=%b/%b exp=1/0", o_we, o_io); end
      tests++; if (o_wreg !== 1'b0 || o_exc !== 2'b00) begin fails++; $display("FAIL sh_wreg_exc got=%b/%b exp=0/00", o_wreg, o_exc); end
      tests++; if (o_stall_cnt !== 2 || o_wb_cnt !== 1) begin fails++; $display("FAIL sh_stall_wb got=%0d/%0d exp=2/1", o_stall_cnt, o_wb_cnt); end
      issue(1'b0, `EXE_SB_OP, 32'h0000_0203, 32'h1234_56A5, 32'h0, 0, 5);
      tests++; if (o_sel !== 4'b0001 || o_bdata !== 32'hA5A5_A5A5) begin fails++; $display("FAIL sb_sel_data got=%b/%h exp=0001/a5a5a5a5", o_sel, o_bdata); end
   endtask

   task automatic test_misaligned();
      issue(1'b0, `EXE_LW_OP, 32'h0000_0103, 32'h0, 32'h0, 99, 5);
      tests++; if (o_req_cnt !== 0) begin fails++; $display("FAIL lw_mis_req got=%0d exp=0", o_req_cnt); end
      tests++; if (o_exc !== 2'b01 || o_wreg !== 1'b0) begin fails++; $display("FAIL lw_mis_exc got=%b/%b exp=01/0", o_exc, o_wreg); end
      tests++; if (o_wb_at !== 1 || o_wb_cnt !== 1) begin fails++; $display("FAIL lw_mis_wb got=at%0d/n%0d exp=at1/n1", o_wb_at, o_wb_cnt); end
      tests++; if (o_stall_cnt !== 1) begin fails++; $display("FAIL lw_mis_stall got=%0d exp=1", o_stall_cnt); end
      issue(1'b0, `EXE_SH_OP, 32'h0000_0201, 32'h0, 32'h0, 99, 5);
      tests++; if (o_exc !== 2'b10 || o_req_cnt !== 0) begin fails++; $display("FAIL sh_mis got=%b/%0d exp=10/0", o_exc, o_req_cnt); end
   endtask

   task automatic test_timeout();
      issue(1'b0, `EXE_SW_OP, 32'hFFFF_0000, 32'h1234_5678, 32'h0, 1000, 20);
      tests++; if (o_io !== 1'b1 || o_sel !== 4'b1111) begin fails++; $display("FAIL to_io_sel got=%b/%b exp=1/1111", o_io, o_sel); end
      tests++; if (o_req_cnt !== 15) begin fails++; $display("FAIL to_req_cycles got=%0d exp=15", o_req_cnt); end
      tests++; if (o_exc !== 2'b11 || o_wreg !== 1'b0) begin fails++; $display("FAIL to_exc got=%b/%b exp=11/0", o_exc, o_wreg); end
      tests++; if (o_wb_at !== 16 || o_wb_cnt !== 1) begin fails++; $display("FAIL to_wb got=at%0d/n%0d exp=at16/n1", o_wb_at, o_wb_cnt); end
      tests++; if (o_stall_cnt !== 16) begin fails++; $display("FAIL to_stall got=%0d exp=16", o_stall_cnt); end
      issue(1'b0, `EXE_LW_OP, 32'hFFFE_FFFC, 32'h0, 32'h0, 0, 4);
      tests++; if (o_io !== 1'b0) begin fails++; $display("FAIL below_io got=%b exp=0", o_io); end
   endtask

   task automatic test_ack_timeout_tie();
      issue(1'b0, `EXE_LW_OP, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 14, 20);
      tests++; if (o_req_cnt !== 15) begin fails++; $display("FAIL tie_req got=%0d exp=15", o_req_cnt); end
      tests++; if (o_exc !== 2'b00 || o_wreg !== 1'b1) begin fails++; $display("FAIL tie_exc got=%b/%b exp=00/1", o_exc, o_wreg); end
      tests++; if (o_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL tie_wdata got=%h exp=deadbeef", o_wdata); end
   endtask

   task automatic test_lanes();
      issue(1'b0, `EXE_LH_OP, 32'h0000_0102, 32'h0, 32'h1234_8765, 0, 5);
      tests++; if (o_sel !== 4'b0011 || o_wdata !== 32'hFFFF_8765) begin fails++; $display("FAIL be_lh got=%b/%h exp=0011/ffff8765", o_sel, o_wdata); end
      issue(1'b0, `EXE_LHU_OP, 32'h0000_0100, 32'h0, 32'h8234_0765, 0, 5);
      tests++; if (o_sel !== 4'b1100 || o_wdata !== 32'h0000_8234) begin fails++; $display("FAIL be_lhu got=%b/%h exp=1100/00008234", o_sel, o_wdata); end
      issue(1'b1, `EXE_LHU_OP, 32'h0000_0102, 32'h0, 32'h1234_8765, 0, 5);
      tests++; if (o_sel !== 4'b1100 || o_wdata !== 32'h0000_1234) begin fails++; $display("FAIL le_lhu got=%b/%h exp=1100/00001234", o_sel, o_wdata); end
      issue(1'b1, `EXE_LB_OP, 32'h0000_0100, 32'h0, 32'h1234_56F0, 0, 5);
      tests++; if (o_sel !== 4'b0001 || o_wdata !== 32'hFFFF_FFF0) begin fails++; $display("FAIL le_lb got=%b/%h exp=0001/fffffff0", o_sel, o_wdata); end
   endtask

   task automatic test_back_to_back();
      int bcnt, stl, wbn;
      logic [31:0] res;
      bus_le.bus_data_i = 32'h8000_0000; bus_le.bus_ack_i = 1'b0;
      @(posedge clk); #1;
      aluop = 8'b0010_0101; addr = 32'h0; wdat = 32'd5; wd = 5'd9; wreg = 1'b1; req_le = 1'b1;
      @(posedge clk); #1;
      aluop = `EXE_LBU_OP; addr = 32'h0000_0103; wdat = 32'h0; wd = 5'd10;
      @(negedge clk);
      tests++; if (wb_le !== 1'b1 || wdata_le !== 32'd5 || wd_le !== 5'd9) begin fails++; $display("FAIL b2b_alu got=%b/%h/%0d exp=1/5/9", wb_le, wdata_le, wd_le); end
      tests++; if (stall_le !== 1'b0 || exc_le !== 2'b00) begin fails++; $display("FAIL b2b_alu_stall got=%b/%b exp=0/00", stall_le, exc_le); end
      @(posedge clk); #1;
      req_le = 1'b0;
      bcnt = 0; stl = 0; wbn = 0; res = 32'hX;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (bus_le.bus_req_o) begin
            bcnt++;
            tests++; if (bus_le.bus_sel_o !== 4'b1000) begin fails++; $display("FAIL b2b_lbu_sel got=%b exp=1000", bus_le.bus_sel_o); end
         end
         if (stall_le) stl++;
         if (wb_le) begin wbn++; res = wdata_le; end
         bus_le.bus_ack_i = bus_le.bus_req_o;
      end
      bus_le.bus_ack_i = 1'b0;
      tests++; if (bcnt !== 1 || wbn !== 1) begin fails++; $display("FAIL b2b_lbu_cnt got=req%0d/wb%0d exp=req1/wb1", bcnt, wbn); end
      tests++; if (res !== 32'h0000_0080) begin fails++; $display("FAIL b2b_lbu_wdata got=%h exp=00000080", res); end
      tests++; if (stl !== 2) begin fails++; $display("FAIL b2b_lbu_stall got=%0d exp=2", stl); end
   endtask

   task automatic test_reset_mid_bus();
      int wbn, stl;
      bus_be.bus_ack_i = 1'b0;
      @(posedge clk); #1;
      aluop = `EXE_LW_OP; addr = 32'h0000_0108; req_be = 1'b1;
      @(posedge clk); #1;
      req_be = 1'b0;
      @(negedge clk);
      tests++; if (bus_be.bus_req_o !== 1'b1) begin fails++; $display("FAIL mid_pre_req got=%b exp=1", bus_be.bus_req_o); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (bus_be.bus_req_o !== 1'b0 || stall_be !== 1'b0) begin fails++; $display("FAIL mid_async_req got=%b/%b exp=0/0", bus_be.bus_req_o, stall_be); end
      @(posedge clk); #2 rst_n = 1'b1;
      wbn = 0; stl = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wb_be) wbn++;
         if (stall_be || bus_be.bus_req_o) stl++;
      end
      tests++; if (wbn !== 0) begin fails++; $display("FAIL mid_no_wb got=%0d exp=0", wbn); end
      tests++; if (stl !== 0) begin fails++; $display("FAIL mid_idle got=%0d exp=0", stl); end
   endtask

   initial begin
      rst_n = 1'b0; req_be = 1'b0; req_le = 1'b0; aluop = 8'h0; addr = 32'h0;
      reg2 = 32'h0; wdat = 32'h0; wd = 5'h0; wreg = 1'b0;
      bus_be.bus_ack_i = 1'b0; bus_le.bus_ack_i = 1'b0;
      bus_be.bus_data_i = 32'h0; bus_le.bus_data_i = 32'h0;
      #12;
      test_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_timeout();
      test_ack_timeout_tie();
      test_lanes();
      test_back_to_back();
      test_reset_mid_bus();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
